usb_timebase: RTL and testbench
===============================

USB_TIMEBASE -- requirements
Module: usb_timebase

Interface
REQ-001 Parameter FRAME_LEN, default 48000: nominal clk_48 cycles per USB full-speed frame (1 ms).
REQ-002 Parameter BIT_DIV, default 4: clk_48 cycles per 12 Mbit/s bit strobe.
REQ-003 Parameter US_DIV, default 48: clk_48 cycles per microsecond strobe.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 clk_48  in  1  48 MHz clock; sole clock of the block, all logic on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 en  in  1  count enable; counters advance only on edges with en=1.
REQ-008 resync  in  1  single-cycle pulse; host SOF observed, realign frame phase.
REQ-009 trim_valid  in  1  trim request valid.
REQ-010 trim_delta  in  4  signed two's-complement frame-length correction, -8..+7 cycles.
REQ-011 trim_ready  out  1  trim request can be accepted.
REQ-012 bit_stb  out  1  one-cycle strobe every BIT_DIV enabled cycles.
REQ-013 us_stb  out  1  one-cycle strobe every US_DIV enabled cycles.
REQ-014 sof_stb  out  1  one-cycle start-of-frame strobe.
REQ-015 frame_num  out  11  USB frame number.

Function
REQ-016 All outputs SHALL be registered; each strobe is high for exactly one clk_48 cycle.
REQ-017 Three independent counters (bit 2b, us 6b, frame cycle 16b) SHALL increment on each enabled edge and wrap to 0 at terminal count (divisor-1).
REQ-018 A strobe SHALL be high in the cycle after its counter's terminal-count edge: with en held high from the first post-reset edge, bit_stb is high after enabled edges 4, 8, ...; us_stb after 48, 96, ...; sof_stb after 48000, 96000, ....
REQ-019 en=0 SHALL freeze all counters and force all strobes low on the next cycle; counting resumes from the held value.
REQ-020 frame_num SHALL increment by 1 in the same cycle sof_stb is asserted, wrapping 2047 -> 0.
REQ-021 Active frame length SHALL be FRAME_LEN + applied trim (47992..48007); the terminal compare uses full 16-bit unsigned arithmetic on the sign-extended delta.
REQ-022 resync=1 at an edge SHALL clear all three counters to 0 and produce sof_stb and frame_num+1 in the next cycle, regardless of en.
REQ-023 resync coincident with a natural frame terminal count SHALL yield exactly one sof_stb and one frame_num increment.
REQ-024 bit_stb and us_stb SHALL NOT be asserted in the cycle following a resync edge.
REQ-025 A trim is accepted on an edge with trim_valid=1 and trim_ready=1; trim_ready SHALL drop in the next cycle.
REQ-026 An accepted trim SHALL apply to the frame in progress only; if accepted on the frame-terminal edge, it applies to the following frame.
REQ-027 The pending trim SHALL be cleared and trim_ready reasserted in the cycle sof_stb is high.
REQ-028 resync SHALL discard any pending trim; that frame and the next use FRAME_LEN unless a new trim is accepted.
REQ-029 trim_delta SHALL be ignored when not accepted; trim_valid may be held high indefinitely.

Reset
REQ-030 rst_n=0 at an edge SHALL clear all counters, pending trim and frame_num, and drive bit_stb, us_stb and sof_stb to 0.
REQ-031 trim_ready SHALL reset to 1 when USB_TIMEBASE_TRIM_EN is defined, 0 otherwise.
REQ-032 Reset SHALL override en, resync and trim_valid; reset mid-frame aborts the frame with no sof_stb.

Configuration
REQ-033 Macro USB_TIMEBASE_TRIM_EN defined: trim handshake and variable frame length as in REQ-021, REQ-025 to REQ-029.
REQ-034 Macro undefined: ports remain; trim_ready tied 0; trim_valid and trim_delta ignored; frame length fixed at FRAME_LEN.

Verification
REQ-035 Reset, en=1 for 100000 cycles -> sof_stb after enabled edges 48000 and 96000, frame_num 0 -> 1 -> 2; bit_stb 25000 pulses; us_stb 2083 pulses.
REQ-036 en toggled 0 for 10 cycles at cycle 20000 -> first sof_stb delayed to cycle 48010; no strobes while en=0.
REQ-037 Trim -8 accepted at cycle 100 -> sof_stb after edge 47992, trim_ready high that cycle; next frame 48000 cycles.
REQ-038 Trim +7 accepted on edge 48000 -> first sof at 48000, second at 96007.
REQ-039 resync at cycle 30000 with pending trim -> sof_stb at 30001, frame_num+1, trim discarded, next sof 48000 cycles later.
REQ-040 frame_num preloaded by 2047 frames then one more sof -> frame_num wraps to 0; rst_n=0 mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/usb_timebase.sv
// usb_timebase: USB full-speed bit/us/frame strobes with SOF resync and optional frame trim (USB_TIMEBASE_TRIM_EN)
module usb_timebase #(
  parameter int FRAME_LEN = 48000,
  parameter int BIT_DIV   = 4,
  parameter int US_DIV    = 48
) (
  input  logic        clk_48,
  input  logic        rst_n,
  input  logic        en,
  input  logic        resync,
  input  logic        trim_valid,
  input  logic [3:0]  trim_delta,
  output logic        trim_ready,
  output logic        bit_stb,
  output logic        us_stb,
  output logic        sof_stb,
  output logic [10:0] frame_num
);
`ifdef USB_TIMEBASE_TRIM_EN
  localparam logic TRIM_EN = 1'b1;
`else
  localparam logic TRIM_EN = 1'b0;
`endif
  localparam int BW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
  localparam int UW = US_DIV > 1 ? $clog2(US_DIV) : 1;
  logic [BW-1:0] bit_cnt;
  logic [UW-1:0] us_cnt;
  logic [15:0]   frm_cnt;
  logic [15:0]   frm_term;
  logic [3:0]    trim_val;
  logic          trim_pend;
  logic          trim_acc;
  logic          bit_tc;
  logic          us_tc;
  logic          frm_tc;
  logic          sof_evt;
  // terminal counts; a pending trim stretches or shrinks the current frame by its sign-extended delta
  always_comb begin
    frm_term = 16'(FRAME_LEN - 1) + (trim_pend ? {{12{trim_val[3]}}, trim_val} : 16'd0);
    bit_tc   = bit_cnt == BW'(BIT_DIV - 1);
    us_tc    = us_cnt == UW'(US_DIV - 1);
    frm_tc   = frm_cnt >= frm_term;
    sof_evt  = resync | (en & frm_tc);
    trim_acc = TRIM_EN & trim_valid & trim_ready;
  end
  // counters, registered strobes, frame number and the single-entry trim holding register
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      us_cnt     <= '0;
      frm_cnt    <= '0;
      bit_stb    <= 1'b0;
      us_stb     <= 1'b0;
      sof_stb    <= 1'b0;
      frame_num  <= '0;
      trim_pend  <= 1'b0;
      trim_val   <= '0;
      trim_ready <= TRIM_EN;
    end else begin
      bit_cnt    <= resync ? '0 : en ? (bit_tc ? '0 : bit_cnt + 1'b1) : bit_cnt;
      us_cnt     <= resync ? '0 : en ? (us_tc ? '0 : us_cnt + 1'b1) : us_cnt;
      frm_cnt    <= resync ? '0 : en ? (frm_tc ? '0 : frm_cnt + 16'd1) : frm_cnt;
      bit_stb    <= en & ~resync & bit_tc;
      us_stb     <= en & ~resync & us_tc;
      sof_stb    <= sof_evt;
      frame_num  <= sof_evt ? frame_num + 11'd1 : frame_num;
      trim_pend  <= resync ? 1'b0 : trim_acc ? 1'b1 : sof_evt ? 1'b0 : trim_pend;
      trim_val   <= (trim_acc & ~resync) ? trim_delta : trim_val;
      trim_ready <= TRIM_EN & (resync | (~trim_acc & (sof_evt | ~trim_pend)));
    end
  end
endmodule

// File: tb/tb_usb_timebase.sv
// tb_usb_timebase: directed scoreboard bench for usb_timebase with a shortened frame
module tb_usb_timebase;
  localparam int FL = 480;
  localparam int BD = 4;
  localparam int UD = 48;
`ifdef USB_TIMEBASE_TRIM_EN
  localparam logic EXP_RDY = 1'b1;
`else
  localparam logic EXP_RDY = 1'b0;
`endif
  logic        clk_48 = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        resync = 1'b0;
  logic        trim_valid = 1'b0;
  logic [3:0]  trim_delta = 4'd0;
  logic        trim_ready;
  logic        bit_stb;
  logic        us_stb;
  logic        sof_stb;
  logic [10:0] frame_num;
  typedef struct {
    int          e;
    logic [10:0] fn;
  } sof_t;
  sof_t exp_q[$];
  int total = 0;
  int bad = 0;
  int edge_no = 0;
  int n_bit = 0;
  int n_us = 0;
  usb_timebase #(.FRAME_LEN(FL), .BIT_DIV(BD), .US_DIV(UD)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .en(en), .resync(resync),
    .trim_valid(trim_valid), .trim_delta(trim_delta), .trim_ready(trim_ready),
    .bit_stb(bit_stb), .us_stb(us_stb), .sof_stb(sof_stb), .frame_num(frame_num)
  );
  always #5 clk_48 = ~clk_48;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic expect_sof(input int e, input int fn);
    exp_q.push_back('{e, 11'(fn)});
  endtask
  task automatic tick;
    sof_t s;
    @(posedge clk_48);
    edge_no++;
    @(negedge clk_48);
    if (bit_stb) n_bit++;
    if (us_stb) n_us++;
    if (sof_stb) begin
      if (exp_q.size() == 0) chk("sof_unexpected", {31'd0, sof_stb}, 32'd0);
      else begin
        s = exp_q.pop_front();
        chk("sof_edge", edge_no, s.e);
        chk("sof_frame_num", {21'd0, frame_num}, {21'd0, s.fn});
      end
    end
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic end_test;
    chk("sof_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    en = 1'b0;
    resync = 1'b0;
    trim_valid = 1'b0;
    trim_delta = 4'd0;
    tick();
    chk("rst_strobes", {bit_stb, us_stb, sof_stb}, 0);
    chk("rst_frame_num", {21'd0, frame_num}, 0);
    chk("rst_trim_ready", {31'd0, trim_ready}, {31'd0, EXP_RDY});
    tick();
    rst_n = 1'b1;
    edge_no = 0;
    n_bit = 0;
    n_us = 0;
  endtask
  initial begin
    do_reset();
    en = 1'b1;
    expect_sof(480, 1);
    expect_sof(960, 2);
    run(3);
    chk("bit_before_first", {31'd0, bit_stb}, 0);
    run(1);
    chk("bit_first", {31'd0, bit_stb}, 1);
    run(996);
    chk("bit_count", n_bit, 250);
    chk("us_count", n_us, 20);
    chk("frame_num_run", {21'd0, frame_num}, 2);
    end_test();
    do_reset();
    en = 1'b1;
    expect_sof(490, 1);
    run(200);
    en = 1'b0;
    repeat (10) begin
      tick();
      chk("gap_quiet", {bit_stb, us_stb, sof_stb}, 0);
    end
    en = 1'b1;
    run(290);
    chk("gap_bit_count", n_bit, 122);
    chk("gap_us_count", n_us, 10);
    end_test();
    do_reset();
    en = 1'b1;
    run(287);
    expect_sof(288, 1);
    expect_sof(768, 2);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_bit_quiet", {31'd0, bit_stb}, 0);
    chk("resync_us_quiet", {31'd0, us_stb}, 0);
    run(532);
    end_test();
    do_reset();
    en = 1'b1;
    run(479);
    expect_sof(480, 1);
    expect_sof(960, 2);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    run(520);
    end_test();
    do_reset();
    for (int i = 1; i <= 2048; i++) begin
      expect_sof(edge_no + 1, i);
      resync = 1'b1;
      tick();
      resync = 1'b0;
      tick();
    end
    chk("fn_wrap", {21'd0, frame_num}, 0);
    expect_sof(edge_no + 1, 1);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    en = 1'b1;
    run(479);
    end_test();
    do_reset();
`ifdef USB_TIMEBASE_TRIM_EN
    en = 1'b1;
    expect_sof(472, 1);
    expect_sof(952, 2);
    run(99);
    trim_valid = 1'b1;
    trim_delta = 4'h8;
    tick();
    trim_valid = 1'b0;
    chk("trim_ready_drop", {31'd0, trim_ready}, 0);
    run(372);
    chk("trim_ready_sof", {31'd0, trim_ready}, 1);
    run(528);
    end_test();
    do_reset();
    en = 1'b1;
    expect_sof(480, 1);
    expect_sof(967, 2);
    run(479);
    trim_valid = 1'b1;
    trim_delta = 4'h7;
    tick();
    trim_valid = 1'b0;
    chk("trim_tc_ready", {31'd0, trim_ready}, 0);
    run(520);
    end_test();
    do_reset();
    en = 1'b1;
    run(49);
    trim_valid = 1'b1;
    trim_delta = 4'h8;
    tick();
    trim_valid = 1'b0;
    run(249);
    expect_sof(300, 1);
    expect_sof(780, 2);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("trim_resync_ready", {31'd0, trim_ready}, 1);
    run(500);
    end_test();
`else
    en = 1'b1;
    trim_valid = 1'b1;
    trim_delta = 4'h8;
    expect_sof(480, 1);
    expect_sof(960, 2);
    run(100);
    chk("trim_ready_tied", {31'd0, trim_ready}, 0);
    run(900);
    trim_valid = 1'b0;
    end_test();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
